// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two common data bus broadcast slots between
// NUM_REQ functional-unit result requesters with rotating round-robin
// priority. Granted results are registered and broadcast one cycle later
// as {tag, data}. A flush drops the results being granted that cycle.
//
// Handshake: a requester transfers its result on a rising clk edge where
// req_valid[i] && req_ready[i]. req_ready is combinational and may rise in
// the same cycle as req_valid. A requester keeps valid/tag/data stable until
// it sees ready, and may drop valid at any time. The CDB side has no
// back-pressure: each slot value is live for exactly one cycle.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [TAG_W+DATA_W-1:0]     cdb1,
  output logic [TAG_W+DATA_W-1:0]     cdb2,
  output logic                        cdb1_valid,
  output logic                        cdb2_valid,
  output logic [15:0]                 conflict_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NUM_REQ + 1);
  localparam int SLOT_W = TAG_W + DATA_W;

  localparam logic [SUM_W-1:0] NUM_REQ_S  = SUM_W'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CONFLICT_T = CNT_W'(2);

  logic [PTR_W-1:0] rr_ptr;

  logic             g1_found;
  logic             g2_found;
  logic [PTR_W-1:0] g1;
  logic [PTR_W-1:0] g2;
  logic [SUM_W-1:0] scan_idx;
  logic             grant_en;
  logic [CNT_W-1:0] valid_count;

  logic [TAG_W-1:0]  g1_tag;
  logic [TAG_W-1:0]  g2_tag;
  logic [DATA_W-1:0] g1_data;
  logic [DATA_W-1:0] g2_data;
  logic [PTR_W-1:0]  last_grant;
  logic [PTR_W-1:0]  next_ptr;

  // Grants are suppressed entirely while reset or flush is high.
  assign grant_en = !reset && !flush;

  // Round-robin scan from rr_ptr with explicit modulo wrap: first valid
  // requester takes slot 1, the second valid one takes slot 2.
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1       = '0;
    g2       = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + SUM_W'(k);
      if (scan_idx >= NUM_REQ_S) begin
        scan_idx = scan_idx - NUM_REQ_S;
      end
      if (req_valid[scan_idx[PTR_W-1:0]]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1       = scan_idx[PTR_W-1:0];
        end else if (!g2_found) begin
          g2_found = 1'b1;
          g2       = scan_idx[PTR_W-1:0];
        end
      end
    end
  end

  // Ready goes only to the (up to two) granted requesters.
  always_comb begin
    req_ready = '0;
    if (grant_en && g1_found) begin
      req_ready[g1] = 1'b1;
    end
    if (grant_en && g2_found) begin
      req_ready[g2] = 1'b1;
    end
  end

  // Number of requesters asserting valid this cycle, for conflict counting.
  always_comb begin
    valid_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_count = valid_count + CNT_W'(req_valid[i]);
    end
  end

  // Select the granted payloads and the pointer that follows the last grant.
  always_comb begin
    g1_tag     = req_tag[g1*TAG_W +: TAG_W];
    g2_tag     = req_tag[g2*TAG_W +: TAG_W];
    g1_data    = req_data[g1*DATA_W +: DATA_W];
    g2_data    = req_data[g2*DATA_W +: DATA_W];
    last_grant = g2_found ? g2 : g1;
    next_ptr   = (last_grant == LAST_REQ) ? '0 : last_grant + PTR_W'(1);
  end

  // Slot registers, round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      cdb1         <= '0;
      cdb2         <= '0;
      cdb1_valid   <= 1'b0;
      cdb2_valid   <= 1'b0;
      conflict_cnt <= '0;
    end else if (flush) begin
      // Idle encoding on both slots; pointer and counter hold.
      cdb1       <= '0;
      cdb2       <= '0;
      cdb1_valid <= 1'b0;
      cdb2_valid <= 1'b0;
    end else begin
      cdb1       <= g1_found ? {g1_tag, g1_data} : SLOT_W'(0);
      cdb2       <= g2_found ? {g2_tag, g2_data} : SLOT_W'(0);
      cdb1_valid <= g1_found;
      cdb2_valid <= g2_found;
      if (g1_found) begin
        rr_ptr <= next_ptr;
      end
      if (valid_count > CONFLICT_T && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two common data bus broadcast slots (cdb1, cdb2) between NUM_REQ functional-unit result requesters.
- Each cycle it grants up to two requesters using a rotating round-robin priority.
- Granted results are registered and broadcast to the reorder buffer and reservation stations one cycle later, in the 38-bit {tag[5:0], data[31:0]} CDB format.
- A flush (branch mispredict) discards results that are in flight.

Parameters:
NUM_REQ, 4, number of result requesters (2..8)
TAG_W, 6, ROB tag width
DATA_W, 32, result data width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  mispredict flush from the reorder buffer, active-high
req_valid  input  NUM_REQ  requester i has a result to broadcast
req_tag  input  NUM_REQ*TAG_W  requester i tag at bits [i*TAG_W +: TAG_W]
req_data  input  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  combinational grant; handshake completes when valid && ready
cdb1  output  TAG_W+DATA_W  broadcast slot 1, {tag, data}
cdb2  output  TAG_W+DATA_W  broadcast slot 2, {tag, data}
cdb1_valid  output  1  slot 1 carries a real result
cdb2_valid  output  1  slot 2 carries a real result
conflict_cnt  output  16  count of cycles with more than 2 valid requests

Behaviour:
- Reset (synchronous):
  - rr_ptr = 0.
  - cdb1 = cdb2 = 0; cdb1_valid = cdb2_valid = 0.
  - conflict_cnt = 0.
  - req_ready = 0 during the reset cycle.
- Idle slot encoding: tag 0, data 0, valid 0. ROB entry 0 is never allocated at head, so tag-0 writes are harmless.
- Grant (combinational, when reset = 0 and flush = 0):
  - Scan requesters in order rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - First valid requester → slot 1 (g1). Second valid requester → slot 2 (g2).
  - req_ready[g1] = req_ready[g2] = 1; all other ready bits = 0.
  - If only one requester is valid, only slot 1 is used.
- Latency:
  - Slot 1 register captures req_tag/req_data of g1 at the handshake edge; slot 2 captures g2.
  - Both appear on cdb1/cdb2 with valid = 1 in the next cycle, i.e. fixed 1-cycle latency.
  - An unused slot loads the idle encoding, so each broadcast lasts exactly one cycle and there are no repeats.
- Pointer update:
  - Two grants: rr_ptr <= (g2+1) mod NUM_REQ.
  - One grant: rr_ptr <= (g1+1) mod NUM_REQ.
  - No grants: rr_ptr unchanged.
- Requester rules:
  - A requester holds valid/tag/data stable until ready is seen.
  - It may deassert valid without penalty.
  - Ready may be asserted combinationally in the same cycle valid rises.
- No back-pressure from the CDB: the ROB accepts both slots every cycle.
- Flush:
  - In the flush cycle, req_ready = 0 for all requesters.
  - Both slots load the idle encoding, so the cycle after flush shows valid = 0.
  - rr_ptr and conflict_cnt are unchanged.
  - A result already on the CDB during the flush cycle is not retracted.
- Reset during an active grant:
  - Reset dominates flush and grant.
  - No handshake completes, and all state returns to reset values.
- conflict_cnt:
  - Increments by 1 in each non-reset, non-flush cycle where popcount(req_valid) > 2.
  - Saturates at 16'hFFFF; no wrap.
- Tag collisions between the two slots are not checked; producers guarantee unique tags.
- NUM_REQ not a power of two: modulo wrap is explicit (NUM_REQ-1 → 0).

Test Plan:
- Reset, then req_valid=0000 for 3 cycles → req_ready=0000; cdb1/cdb2 = 0 with valid=0; conflict_cnt=0.
- Single request: rr_ptr=0, req_valid=0100, tag=5, data=32'hDEADBEEF → req_ready=0100 this cycle; next cycle cdb1={6'd5,32'hDEADBEEF}, cdb1_valid=1, cdb2_valid=0; rr_ptr=3.
- Rotation with all requesters held valid (tags 1..4) for 4 cycles, starting rr_ptr=0:
  - grants (0,1), (2,3), (0,1), (2,3);
  - conflict_cnt=4;
  - each broadcast appears exactly one cycle after its grant.
- Wrap: rr_ptr=3, req_valid=1001 → slot1=req3, slot2=req0; rr_ptr becomes 1.
- Flush: all requesters valid with flush=1 → req_ready=0000; next cycle both slots invalid with tag 0; rr_ptr and conflict_cnt unchanged. In the cycle after, grants resume from the saved rr_ptr.
- Saturation/reset:
  - Force 65,537 conflict cycles → conflict_cnt=16'hFFFF.
  - Assert reset alongside a valid request → no ready; next cycle all outputs are 0 and rr_ptr=0.
